// File: rtl/dmem_arbiter.sv
// Two-port arbiter around a DEPTH-word data memory shared by the pipeline MEM stage (core)
// and the external loader/debug port. Grants are combinational; read data returns one cycle later.
module dmem_arbiter #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        RN,
    input  logic        prio_core,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        addr_err,
    output logic [2:0]  starve_cnt
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] MaxWaitCnt = 3'(MAX_WAIT);

    logic [31:0] mem [DEPTH];
    logic        last_gnt_q;   // 0 = core, 1 = loader
    logic [2:0]  starve_q, starve_d;

    logic        acc;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;

    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (c_req && l_req) begin
            if (prio_core) begin
                // Loader is force-granted once it has waited MAX_WAIT cycles.
                if (starve_q == MaxWaitCnt) l_gnt = 1'b1;
                else                        c_gnt = 1'b1;
            end else if (last_gnt_q) begin
                c_gnt = 1'b1;
            end else begin
                l_gnt = 1'b1;
            end
        end else if (c_req) begin
            c_gnt = 1'b1;
        end else if (l_req) begin
            l_gnt = 1'b1;
        end
    end

    always_comb begin
        acc       = c_gnt | l_gnt;
        sel_we    = l_gnt ? l_we    : c_we;
        sel_addr  = l_gnt ? l_addr  : c_addr;
        sel_wdata = l_gnt ? l_wdata : c_wdata;
        in_range  = (sel_addr < DEPTH);
        idx       = sel_addr[AW-1:0];
        rd_word   = in_range ? mem[idx] : 32'd0;
    end

    always_comb begin
        starve_d = 3'd0;
        if (l_req && !l_gnt) begin
            starve_d = (starve_q == MaxWaitCnt) ? starve_q : starve_q + 3'd1;
        end
    end

    assign starve_cnt = starve_q;

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'd0;
            last_gnt_q <= 1'b1;
            starve_q   <= 3'd0;
            c_rvalid   <= 1'b0;
            l_rvalid   <= 1'b0;
            c_rdata    <= 32'd0;
            l_rdata    <= 32'd0;
            addr_err   <= 1'b0;
        end else begin
            c_rvalid <= c_gnt && !c_we;
            l_rvalid <= l_gnt && !l_we;
            addr_err <= acc && !in_range;
            if (c_gnt && !c_we) c_rdata <= rd_word;
            if (l_gnt && !l_we) l_rdata <= rd_word;
            if (acc && sel_we && in_range) mem[idx] <= sel_wdata;
            if (acc) last_gnt_q <= l_gnt;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter; expectations come from a cycle-level
// behavioural model of the arbitration and memory rules.
module tb_dmem_arbiter;
    localparam int DEPTH    = 32;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        RN  = 1'b1;
    logic        prio_core = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        c_gnt, c_rvalid;
    logic [31:0] c_rdata;
    logic        l_req = 1'b0, l_we = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        addr_err;
    logic [2:0]  starve_cnt;

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .RN         (RN),
        .prio_core  (prio_core),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_gnt      (c_gnt),
        .c_rvalid   (c_rvalid),
        .c_rdata    (c_rdata),
        .l_req      (l_req),
        .l_we       (l_we),
        .l_addr     (l_addr),
        .l_wdata    (l_wdata),
        .l_gnt      (l_gnt),
        .l_rvalid   (l_rvalid),
        .l_rdata    (l_rdata),
        .addr_err   (addr_err),
        .starve_cnt (starve_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_last;      // port that won the previous handshake
    int          m_starve;
    logic [31:0] m_c_rdata, m_l_rdata;
    int          last_winner;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_last    = 1;
        m_starve  = 0;
        m_c_rdata = 32'd0;
        m_l_rdata = 32'd0;
    endtask

    // Called at posedge+1; drives one cycle, checks grants mid-cycle and results after the edge.
    task automatic do_cycle(input logic prio, input logic cr, input logic cw,
                            input logic [31:0] ca, input logic [31:0] cd,
                            input logic lr, input logic lw,
                            input logic [31:0] la, input logic [31:0] ld);
        int winner;
        logic [31:0] w_addr, w_data;
        logic w_we;
        prio_core = prio;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
        winner = -1;
        if (cr && lr) begin
            if (prio) winner = (m_starve == MAX_WAIT) ? 1 : 0;
            else      winner = 1 - m_last;
        end else if (cr) winner = 0;
        else if (lr)     winner = 1;
        #2;
        check("c_gnt", 32'(c_gnt), 32'(winner == 0));
        check("l_gnt", 32'(l_gnt), 32'(winner == 1));
        check("starve_cnt", 32'(starve_cnt), 32'(m_starve));
        @(posedge clk);
        #1;
        w_addr = (winner == 1) ? la : ca;
        w_data = (winner == 1) ? ld : cd;
        w_we   = (winner == 1) ? lw : cw;
        if (winner >= 0 && !w_we) begin
            if (winner == 0) m_c_rdata = (w_addr < DEPTH) ? m_mem[w_addr[4:0]] : 32'd0;
            else             m_l_rdata = (w_addr < DEPTH) ? m_mem[w_addr[4:0]] : 32'd0;
        end
        if (winner >= 0 && w_we && w_addr < DEPTH) m_mem[w_addr[4:0]] = w_data;
        if (winner >= 0) m_last = winner;
        if (lr && winner != 1) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
        else                   m_starve = 0;
        last_winner = winner;
        check("c_rvalid", 32'(c_rvalid), 32'(winner == 0 && !cw));
        check("l_rvalid", 32'(l_rvalid), 32'(winner == 1 && !lw));
        check("c_rdata", c_rdata, m_c_rdata);
        check("l_rdata", l_rdata, m_l_rdata);
        check("addr_err", 32'(addr_err), 32'(winner >= 0 && w_addr >= DEPTH));
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        @(posedge clk);
        #1;
        RN = 1'b0;
        check("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        check("rst_l_rvalid", 32'(l_rvalid), 32'd0);
        check("rst_c_rdata", c_rdata, 32'd0);
        check("rst_l_rdata", l_rdata, 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_starve", 32'(starve_cnt), 32'd0);

        // 1: loader write then core read
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd3, 32'hDEADBEEF);
        do_cycle(1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_c_rdata", c_rdata, 32'hDEADBEEF);
        check("t1_c_rvalid", 32'(c_rvalid), 32'd1);
        idle();

        // 2: round-robin alternation; first tie after the core's last win goes to the loader
        do_cycle(1'b0, 1'b0, 1'b1, 32'd1, 32'h11111111, 1'b1, 1'b1, 32'd2, 32'h22222222);
        for (int i = 0; i < 6; i++)
            do_cycle(1'b0, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
        idle();

        // 3: core priority with the starvation bound
        for (int i = 0; i < 12; i++)
            do_cycle(1'b1, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
        idle();

        // 4: out-of-range write is dropped, out-of-range read returns 0
        do_cycle(1'b0, 1'b1, 1'b1, 32'd40, 32'h12345678, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t4_err", 32'(addr_err), 32'd1);
        for (int a = 0; a < DEPTH; a++)
            do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'(a), 32'd0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'd40, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t4_rd_err", 32'(addr_err), 32'd1);
        check("t4_rd_data", c_rdata, 32'd0);

        // 5: read-after-write across ports in consecutive cycles
        do_cycle(1'b0, 1'b1, 1'b1, 32'd7, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0, 32'd0);
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd7, 32'd0);
        check("t5_l_rdata", l_rdata, 32'hA5A5A5A5);
        idle();

        // Randomized traffic, including out-of-range addresses
        for (int i = 0; i < 300; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 39)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 39)), $urandom);
        end
        idle();

        // 6: reset lands on the edge that would deliver a granted read
        do_cycle(1'b0, 1'b1, 1'b1, 32'd9, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0, 32'd0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'd9;
        #2;
        check("t6_c_gnt", 32'(c_gnt), 32'd1);
        #1;
        RN = 1'b1;
        @(posedge clk);
        #1;
        check("t6_c_rvalid", 32'(c_rvalid), 32'd0);
        check("t6_c_rdata", c_rdata, 32'd0);
        RN = 1'b0;
        c_req = 1'b0;
        model_reset();
        for (int a = 0; a < DEPTH; a++)
            do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'(a), 32'd0);
        model_reset();
        RN = 1'b1;
        #2;
        RN = 1'b0;
        @(posedge clk);
        #1;
        do_cycle(1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 1'b1, 1'b0, 32'd9, 32'd0);
        check("t6_first_tie", 32'(last_winner), 32'd0);
        check("t6_mem9", c_rdata, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Owns the 32-word data memory and shares it between two requesters: port 0, the pipeline MEM stage (LW/SW), and port 1, the external loader/debug port used to preload and inspect data memory.
- Arbitrates per cycle using round-robin or core-priority mode, with a starvation bound on the loader.
- Performs single-word writes and one-cycle-latency reads, and flags out-of-range addresses.

Parameters:
- DEPTH, 32, number of 32-bit data memory words.
- MAX_WAIT, 4, number of consecutive cycles the loader may be refused in priority mode before it is force-granted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RN  in  1  asynchronous, active-high reset.
- prio_core  in  1  1 = core-priority mode; 0 = round-robin.
- c_req  in  1  core request.
- c_we  in  1  core write enable (1 = SW, 0 = LW).
- c_addr  in  32  core word address.
- c_wdata  in  32  core store data.
- c_gnt  out  1  core granted this cycle (combinational).
- c_rvalid  out  1  core read data valid.
- c_rdata  out  32  core read data.
- l_req, l_we, l_addr[31:0], l_wdata[31:0]  in  loader equivalents of the core inputs.
- l_gnt, l_rvalid, l_rdata[31:0]  out  loader equivalents of the core outputs.
- addr_err  out  1  pulse: the granted access used an address >= DEPTH.
- starve_cnt  out  3  current loader wait count (debug).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and RN.
- Reset (RN=1, asynchronous), all of the following take effect:
  - Every memory word is cleared to 0.
  - c_rvalid, l_rvalid, addr_err = 0; c_rdata, l_rdata = 0.
  - starve_cnt = 0; last_gnt = 1 (loader), so the core wins the first tie.
  - Reset asserted mid-access cancels any pending rvalid.
- Grant logic is combinational from req inputs and registered state. At most one gnt is high per cycle.
  - Only one requester high: it is granted.
  - Both high, prio_core=0: grant the port that is not last_gnt.
  - Both high, prio_core=1: grant the core, unless starve_cnt == MAX_WAIT, in which case grant the loader.
  - A request is only counted as a handshake when req && gnt in the same cycle. Refused requesters hold req and inputs stable; the arbiter does not latch refused requests.
- Access, at the rising edge of a granted cycle:
  - Write (we=1, addr < DEPTH): mem[addr] <= wdata. Visible to a read granted in the following cycle.
  - Read (we=0): on the next cycle, rvalid of the granted port = 1 for exactly one cycle, and rdata = mem[addr] (0 if addr >= DEPTH). rdata holds its value until the next read for that port.
  - addr >= DEPTH: the write is dropped, and addr_err = 1 for one cycle, registered on the same edge as rvalid timing.
  - Index with addr[4:0] only after the range check; no wrap-around aliasing.
- State updates:
  - last_gnt updates to the granted port on each handshake; it is unchanged in idle cycles.
  - starve_cnt increments when l_req=1 and l_gnt=0, saturating at MAX_WAIT.
  - starve_cnt resets to 0 when the loader is granted or l_req=0.
- Read-after-write, same address, consecutive cycles (either port): the read returns the new data.
- Latency: grant 0 cycles, read data 1 cycle. Throughput: one access per cycle total.

Test Plan:
1. Reset, then loader writes mem[3]=0xDEADBEEF, then core reads addr 3 -> c_gnt=1 in the read cycle; next cycle c_rvalid=1, c_rdata=0xDEADBEEF, l_rvalid=0.
2. prio_core=0, both request continuously (core reads addr 1, loader reads addr 2) -> grants alternate core, loader, core, loader starting with the core; rvalid pulses alternate with matching data.
3. prio_core=1, both request continuously -> core granted for 4 cycles (starve_cnt 1,2,3,4), loader granted in the 5th, starve_cnt=0 on the next cycle, then the pattern repeats.
4. Core writes addr 40 with 0x12345678 -> addr_err=1 for one cycle, no memory word changes (reads of 0..31 unchanged), c_rvalid stays 0. A core read of addr 40 -> c_rvalid=1, c_rdata=0, addr_err=1.
5. Core writes mem[7]=0xA5A5A5A5 in cycle N, loader reads addr 7 in cycle N+1 -> l_rdata=0xA5A5A5A5 at N+2.
6. Assert RN the cycle after a granted read -> c_rvalid stays 0, all memory reads return 0 afterwards, and the first tie goes to the core.
